// File: rtl/fwd_pkg.sv
// Shared select encodings, stage-tag record and tag helpers for the
// EX-stage forwarding / load-use hazard controller.
package fwd_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
  } stage_tag_t;

  // A stage only produces a forwardable result if it really writes a non-$0 register.
  function automatic logic tagWrites(input stage_tag_t t);
    return t.v && t.rw && (t.rd != REG_ZERO);
  endfunction

  function automatic logic [1:0] selectFwd(input stage_tag_t exTag,
                                           input stage_tag_t memTag,
                                           input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = FWD_REG;
    if (tagWrites(exTag) && (exTag.rd == src)) begin
      sel = FWD_MEM;
    end else if (tagWrites(memTag) && (memTag.rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// EX/MEM/WB destination-tag shift register; a bubble clears the tag
// entering EX while older tags keep advancing.
module hazard_tag_pipe
  import fwd_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  stage_tag_t idTag,
  input  logic       bubble,
  output stage_tag_t exTag,
  output stage_tag_t memTag,
  output stage_tag_t wbTag
);

  stage_tag_t exTag_q, exTag_d;
  stage_tag_t memTag_q;
  stage_tag_t wbTag_q;

  always_comb begin
    exTag_d = idTag;
    if (bubble) begin
      exTag_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      exTag_q  <= '0;
      memTag_q <= '0;
      wbTag_q  <= '0;
    end else begin
      exTag_q  <= exTag_d;
      memTag_q <= exTag_q;
      wbTag_q  <= memTag_q;
    end
  end

  assign exTag  = exTag_q;
  assign memTag = memTag_q;
  assign wbTag  = wbTag_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control beside the ID/EX register.
// Optional stall-cycle counter is built only when STALL_COUNT_EN is defined.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W,
  parameter int CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic [REG_ADDR_W-1:0] idRd,
  input  logic                  idRegWrite,
  input  logic                  idMemRead,
  input  logic                  flush,
  output logic [1:0]            fwdA,
  output logic [1:0]            fwdB,
  output logic                  stall,
  output logic                  exValid
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]      stallCount
`endif
);

  stage_tag_t idTag;
  stage_tag_t exTag;
  stage_tag_t memTag;
  stage_tag_t wbTag;
  logic       hazard;
  logic       bubble;
  logic [1:0] fwdA_q, fwdA_d;
  logic [1:0] fwdB_q, fwdB_d;
  logic       unusedTags;

  assign idTag = '{v: idValid, rd: idRd, rw: idRegWrite, mr: idMemRead};

  hazard_tag_pipe u_tagPipe (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .idTag  (idTag),
    .bubble (bubble),
    .exTag  (exTag),
    .memTag (memTag),
    .wbTag  (wbTag)
  );

  // WB tag and MEM load flag are tracked but no select depends on them.
  assign unusedTags = ^{wbTag, memTag.mr};

  assign hazard = idValid && exTag.v && exTag.mr && tagWrites(exTag) &&
                  ((exTag.rd == idRs) || (exTag.rd == idRt));
  assign stall  = hazard && !flush;
  assign bubble = flush || stall || !idValid;

  always_comb begin
    fwdA_d = FWD_REG;
    fwdB_d = FWD_REG;
    if (!bubble) begin
      fwdA_d = selectFwd(exTag, memTag, idRs);
      fwdB_d = selectFwd(exTag, memTag, idRt);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fwdA_q <= FWD_REG;
      fwdB_q <= FWD_REG;
    end else begin
      fwdA_q <= fwdA_d;
      fwdB_q <= fwdB_d;
    end
  end

  assign fwdA    = fwdA_q;
  assign fwdB    = fwdB_q;
  assign exValid = exTag.v;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] stallCount_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stallCount_q <= '0;
    end else if (stall) begin
      stallCount_q <= stallCount_q + 1'b1;
    end
  end

  assign stallCount = stallCount_q;
`endif

endmodule
